// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the unified-memory port arbiter.
//   arb_state_t : arbiter FSM states
//   owner_t     : which requester owns the current transaction
//   W_EN_NONE   : byte-enable value that marks a read
//   WDOG_W      : width of the grant watchdog / starvation counters
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GRANT_IF = 2'd1,
        GRANT_DM = 2'd2,
        RESP     = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWNER_IF = 1'b0,
        OWNER_DM = 1'b1
    } owner_t;

    localparam logic [3:0] W_EN_NONE = 4'b0000;
    localparam int         WDOG_W    = 8;

endpackage

// File: rtl/mem_port_arbiter_arb_watchdog.sv
// Loadable saturating down-counter with a terminal-count flag.
// Used as the memory-ack watchdog and, when the starvation guard is
// built in, as the consecutive-DM-grant counter.
//   clk, rst    : clock, asynchronous active-high reset (count <= RESET_VALUE)
//   load        : load load_value (has priority over dec)
//   load_value  : value to load
//   dec         : decrement by one, holding at zero
//   expire      : count is zero
module mem_port_arbiter_arb_watchdog #(
    parameter int             W           = 8,
    parameter logic [W-1:0]   RESET_VALUE = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         dec,
    output logic         expire
);

    logic [W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= RESET_VALUE;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign expire = (count == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter for one single-port unified memory shared by the fetch stage
// (read-only) and the memory stage (read/write with byte enables).
// One requester is granted per transaction; the memory port is driven from
// a latched copy of the granted request, and read data is returned with a
// one-cycle ready pulse. A watchdog forces completion (rdata = 0, err pulse)
// if mem_ack does not arrive within ACK_TIMEOUT grant cycles.
//
// Optional build macro: STARVE_GUARD_EN -- after MAX_DM_RUN consecutive DM
// grants taken while fetch was waiting, fetch wins the next tie.
//
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   if_req/if_addr               fetch request (held until if_ready)
//   if_rdata/if_ready            fetch read data, one-cycle completion pulse
//   dm_req/dm_addr/dm_wdata/dm_w_en  data request (w_en == 0 is a load)
//   dm_rdata/dm_ready            load data, one-cycle completion pulse
//   mem_req/mem_addr/mem_wdata/mem_w_en  memory port request
//   mem_rdata/mem_ack            memory read data, completion
//   if_stall/dm_stall            request outstanding and not completing
//   err                          one-cycle pulse when a grant timed out
//
// state    | meaning
// IDLE     | no transaction; arbitrate on current requests
// GRANT_IF | fetch owns the memory port, waiting for mem_ack
// GRANT_DM | data stage owns the memory port, waiting for mem_ack
// RESP     | ready pulse to the owner; memory port idle
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int ACK_TIMEOUT = 15,
    parameter int MAX_DM_RUN  = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_ready,
    input  logic          dm_req,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    input  logic [3:0]    dm_w_en,
    output logic [DW-1:0] dm_rdata,
    output logic          dm_ready,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic [3:0]    mem_w_en,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack,
    output logic          if_stall,
    output logic          dm_stall,
    output logic          err
);

    if ((ACK_TIMEOUT < 1) || (ACK_TIMEOUT > 255)) begin : g_bad_ack_timeout
        $error("ACK_TIMEOUT must be within 1..255");
    end
    if ((MAX_DM_RUN < 1) || (MAX_DM_RUN > 255)) begin : g_bad_max_dm_run
        $error("MAX_DM_RUN must be within 1..255");
    end

    // Loaded while idle so that grant cycle n sees ACK_TIMEOUT-n; zero marks
    // the last permitted grant cycle.
    localparam logic [WDOG_W-1:0] ACK_LOAD = WDOG_W'(ACK_TIMEOUT - 1);

    arb_state_t    state, state_next;
    owner_t        owner;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [3:0]    w_en_q;
    logic [DW-1:0] if_rdata_q, dm_rdata_q;
    logic          timed_out_q;
    logic          timeout;
    logic          in_grant;
    logic          wdog_expire;
    logic          grant_dm_sel;

    assign in_grant = (state == GRANT_IF) || (state == GRANT_DM);

    mem_port_arbiter_arb_watchdog #(
        .W           (WDOG_W),
        .RESET_VALUE (ACK_LOAD)
    ) u_ack_wdog (
        .clk        (clk),
        .rst        (rst),
        .load       (state == IDLE),
        .load_value (ACK_LOAD),
        .dec        (in_grant),
        .expire     (wdog_expire)
    );

`ifdef STARVE_GUARD_EN
    // Counts down from MAX_DM_RUN on DM grants taken while fetch waits;
    // at zero fetch wins a tie. Any fetch grant restores the full budget.
    localparam logic [WDOG_W-1:0] STARVE_LOAD = WDOG_W'(MAX_DM_RUN);
    logic starve_expire;

    mem_port_arbiter_arb_watchdog #(
        .W           (WDOG_W),
        .RESET_VALUE (STARVE_LOAD)
    ) u_starve (
        .clk        (clk),
        .rst        (rst),
        .load       ((state == IDLE) && (state_next == GRANT_IF)),
        .load_value (STARVE_LOAD),
        .dec        ((state == IDLE) && (state_next == GRANT_DM) && if_req),
        .expire     (starve_expire)
    );

    assign grant_dm_sel = dm_req && !(if_req && starve_expire);
`else
    assign grant_dm_sel = dm_req;
`endif

    always_comb begin
        state_next = state;
        timeout    = 1'b0;
        case (state)
            IDLE: begin
                if (grant_dm_sel) begin
                    state_next = GRANT_DM;
                end else if (if_req) begin
                    state_next = GRANT_IF;
                end
            end
            GRANT_IF, GRANT_DM: begin
                // A late ack on the final permitted cycle still counts.
                if (mem_ack) begin
                    state_next = RESP;
                end else if (wdog_expire) begin
                    state_next = RESP;
                    timeout    = 1'b1;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            owner       <= OWNER_IF;
            addr_q      <= '0;
            wdata_q     <= '0;
            w_en_q      <= W_EN_NONE;
            timed_out_q <= 1'b0;
        end else begin
            state       <= state_next;
            timed_out_q <= timeout;
            if ((state == IDLE) && (state_next == GRANT_DM)) begin
                owner   <= OWNER_DM;
                addr_q  <= dm_addr;
                wdata_q <= dm_wdata;
                w_en_q  <= dm_w_en;
            end else if ((state == IDLE) && (state_next == GRANT_IF)) begin
                owner   <= OWNER_IF;
                addr_q  <= if_addr;
                wdata_q <= '0;
                w_en_q  <= W_EN_NONE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else if (in_grant && (mem_ack || wdog_expire)) begin
            if (state == GRANT_IF) begin
                if_rdata_q <= mem_ack ? mem_rdata : '0;
            end else begin
                dm_rdata_q <= mem_ack ? mem_rdata : '0;
            end
        end
    end

    assign mem_req   = in_grant;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_w_en  = w_en_q;

    assign if_ready  = (state == RESP) && (owner == OWNER_IF);
    assign dm_ready  = (state == RESP) && (owner == OWNER_DM);
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign err       = timed_out_q;

    assign if_stall  = if_req && !if_ready;
    assign dm_stall  = dm_req && !dm_ready;

endmodule

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
module tb_mem_port_arbiter;

    localparam int AW          = 32;
    localparam int DW          = 32;
    localparam int ACK_TIMEOUT = 15;
    localparam int MAX_DM_RUN  = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic [DW-1:0] if_rdata;
    logic          if_ready;
    logic          dm_req = 1'b0;
    logic [AW-1:0] dm_addr = '0;
    logic [DW-1:0] dm_wdata = '0;
    logic [3:0]    dm_w_en = '0;
    logic [DW-1:0] dm_rdata;
    logic          dm_ready;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [3:0]    mem_w_en;
    logic [DW-1:0] mem_rdata = '0;
    logic          mem_ack = 1'b0;
    logic          if_stall;
    logic          dm_stall;
    logic          err;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .AW(AW), .DW(DW), .ACK_TIMEOUT(ACK_TIMEOUT), .MAX_DM_RUN(MAX_DM_RUN)
    ) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .dm_req(dm_req), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_w_en(dm_w_en),
        .dm_rdata(dm_rdata), .dm_ready(dm_ready),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_w_en(mem_w_en),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .if_stall(if_stall), .dm_stall(dm_stall), .err(err)
    );

    typedef struct {
        bit            is_dm;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [3:0]    w_en;
    } grant_t;

    typedef struct {
        bit            is_dm;
        bit            is_load;
        bit            timed;
        logic [DW-1:0] data;
        int            cyc;
    } resp_t;

    grant_t grant_q[$];
    resp_t  resp_q[$];

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // ---------------- stimulus + memory responder ----------------
    int            force_delay = -1;
    bit            use_force_data = 1'b0;
    logic [DW-1:0] force_data = '0;
    int            if_left = 0;
    int            dm_left = 0;
    int            rate = 0;
    int            ack_cnt = -1;
    logic [DW-1:0] mem_data = '0;
    bit            cur_owner_dm = 1'b0;
`ifdef STARVE_GUARD_EN
    int            starve = 0;
`endif

    function automatic int rand_delay();
        int sel;
        sel = int'($urandom_range(0, 9));
        if (sel < 6) return int'($urandom_range(0, 2));
        if (sel < 9) return int'($urandom_range(3, 8));
        return int'($urandom_range(13, 18));
    endfunction

    task automatic step();
        logic          s_if, s_dm, ri, rd, mr_prev, was_idle;
        logic [AW-1:0] s_if_addr, s_dm_addr;
        logic [DW-1:0] s_dm_wdata;
        logic [3:0]    s_dm_w_en;
        grant_t        g;
        resp_t         r;
        int            d;
        s_if = if_req;  s_dm = dm_req;
        s_if_addr = if_addr;  s_dm_addr = dm_addr;
        s_dm_wdata = dm_wdata;  s_dm_w_en = dm_w_en;
        ri = if_ready;  rd = dm_ready;  mr_prev = mem_req;
        was_idle = (resp_q.size() == 0) && !mr_prev;
        @(posedge clk); #1;
        if (was_idle && (s_if || s_dm)) check("grant_start", mem_req, 1'b1);
        if (mem_req && !mr_prev) begin
            g.is_dm = s_dm;
`ifdef STARVE_GUARD_EN
            if (s_dm && s_if && (starve == MAX_DM_RUN)) g.is_dm = 1'b0;
            if (!g.is_dm) starve = 0;
            else if (s_if) starve++;
`endif
            g.addr  = g.is_dm ? s_dm_addr  : s_if_addr;
            g.wdata = g.is_dm ? s_dm_wdata : '0;
            g.w_en  = g.is_dm ? s_dm_w_en  : 4'h0;
            grant_q.push_back(g);
            cur_owner_dm = g.is_dm;
            d = (force_delay >= 0) ? force_delay : rand_delay();
            ack_cnt  = d;
            mem_data = use_force_data ? force_data : $urandom;
            r.is_dm   = g.is_dm;
            r.is_load = (g.w_en == 4'h0);
            r.timed   = (d + 1 > ACK_TIMEOUT);
            r.data    = r.timed ? '0 : mem_data;
            r.cyc     = cyc + (r.timed ? ACK_TIMEOUT : d + 1);
            resp_q.push_back(r);
        end
        if (mem_req) begin
            if (ack_cnt == 0) begin
                mem_ack = 1'b1;  mem_rdata = mem_data;  ack_cnt = -1;
            end else begin
                mem_ack = 1'b0;  mem_rdata = $urandom;
                if (ack_cnt > 0) ack_cnt--;
            end
            // The owner's inputs wander during its grant; the port must not follow.
            if (cur_owner_dm) begin
                dm_addr = $urandom;  dm_wdata = $urandom;  dm_w_en = 4'($urandom);
            end else begin
                if_addr = $urandom;
            end
        end else begin
            mem_ack   = 1'($urandom_range(0, 1));
            mem_rdata = $urandom;
        end
        if (ri) if_req = 1'b0;
        if (rd) dm_req = 1'b0;
        if (!if_req && (if_left > 0) && (int'($urandom_range(0, 99)) < rate)) begin
            if_req = 1'b1;  if_addr = $urandom & 32'hFFFF_FFFC;  if_left--;
        end
        if (!dm_req && (dm_left > 0) && (int'($urandom_range(0, 99)) < rate)) begin
            dm_req   = 1'b1;
            dm_addr  = $urandom & 32'hFFFF_FFFC;
            dm_wdata = $urandom;
            dm_w_en  = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            dm_left--;
        end
    endtask

    task automatic drain(input int bound, input string name);
        int n;
        n = 0;
        while ((if_req || dm_req || (if_left > 0) || (dm_left > 0) || (resp_q.size() > 0))
               && (n < bound)) begin
            step();
            n++;
        end
        check({name, "_completes"}, (n < bound), 1'b1);
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic          prev_mr = 1'b0;
    logic [DW-1:0] last_if = '0;
    logic [DW-1:0] last_dm = '0;
    bit            last_dm_valid = 1'b1;
    grant_t        cur_g;
    resp_t         mr;
    bit            exp_if, exp_dm;

    always @(negedge clk) begin
        if (rst) begin
            prev_mr = 1'b0;  last_if = '0;  last_dm = '0;  last_dm_valid = 1'b1;
        end else begin
            if (mem_req && !prev_mr) begin
                if (grant_q.size() == 0) begin
                    checks++;  errors++;
                    $display("FAIL grant_expected: got unexpected mem_req at cycle %0d", cyc);
                    cur_g.is_dm = 1'b0;  cur_g.addr = mem_addr;
                    cur_g.wdata = mem_wdata;  cur_g.w_en = mem_w_en;
                end else begin
                    cur_g = grant_q.pop_front();
                end
            end
            if (mem_req) begin
                check("mem_addr",  mem_addr,  cur_g.addr);
                check("mem_wdata", mem_wdata, cur_g.wdata);
                check("mem_w_en",  mem_w_en,  cur_g.w_en);
            end
            while ((resp_q.size() > 0) && (resp_q[0].cyc < cyc)) begin
                checks++;  errors++;
                $display("FAIL ready_missed: got no ready expected one at cycle %0d", resp_q[0].cyc);
                void'(resp_q.pop_front());
            end
            exp_if = (resp_q.size() > 0) && (resp_q[0].cyc == cyc) && !resp_q[0].is_dm;
            exp_dm = (resp_q.size() > 0) && (resp_q[0].cyc == cyc) &&  resp_q[0].is_dm;
            check("if_ready", if_ready, exp_if);
            check("dm_ready", dm_ready, exp_dm);
            check("err", err, (exp_if || exp_dm) && resp_q[0].timed);
            check("if_stall", if_stall, if_req && !exp_if);
            check("dm_stall", dm_stall, dm_req && !exp_dm);
            if (exp_if || exp_dm) begin
                mr = resp_q.pop_front();
                if (!mr.is_dm) begin
                    check("if_rdata", if_rdata, mr.data);
                    last_if = mr.data;
                    if (last_dm_valid) check("dm_rdata_hold", dm_rdata, last_dm);
                end else begin
                    if (mr.is_load) begin
                        check("dm_rdata", dm_rdata, mr.data);
                        last_dm = mr.data;  last_dm_valid = 1'b1;
                    end else begin
                        last_dm_valid = 1'b0;
                    end
                    check("if_rdata_hold", if_rdata, last_if);
                end
            end
            prev_mr = mem_req;
        end
    end

    // ---------------- sequence ----------------
    initial begin
        #12;
        check("rst_mem_req",  mem_req,  1'b0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_w_en", mem_w_en, 4'h0);
        check("rst_if_ready", if_ready, 1'b0);
        check("rst_dm_ready", dm_ready, 1'b0);
        check("rst_err",      err,      1'b0);
        check("rst_if_rdata", if_rdata, 32'h0);
        check("rst_dm_rdata", dm_rdata, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        // zero-wait fetch
        force_delay = 0;  use_force_data = 1'b1;  force_data = 32'hDEAD_BEEF;
        if_req = 1'b1;  if_addr = 32'h100;
        drain(20, "fetch_zero_wait");

        // simultaneous requests: store goes first
        force_data = 32'hCAFE_0001;
        if_req = 1'b1;  if_addr = 32'h200;
        dm_req = 1'b1;  dm_addr = 32'h300;  dm_wdata = 32'h1234_5678;  dm_w_en = 4'hF;
        drain(30, "tie_dm_first");

        // ack delayed to the fifth grant cycle
        force_delay = 4;  force_data = 32'h0BAD_F00D;
        if_req = 1'b1;  if_addr = 32'h104;
        drain(30, "delayed_ack");

        // ack on the last permitted grant cycle
        force_delay = ACK_TIMEOUT - 1;  force_data = 32'h5555_AAAA;
        dm_req = 1'b1;  dm_addr = 32'h440;  dm_w_en = 4'h0;
        drain(40, "ack_at_limit");

        // no ack at all
        force_delay = 1000;
        if_req = 1'b1;  if_addr = 32'h108;
        drain(40, "timeout");

        // reset while data stage holds the port
        dm_req = 1'b1;  dm_addr = 32'h500;  dm_wdata = 32'h7777_0000;  dm_w_en = 4'h3;
        step();  step();  step();
        #2;
        rst = 1'b1;
        #1;
        check("reset_mem_req",  mem_req,  1'b0);
        check("reset_dm_ready", dm_ready, 1'b0);
        dm_req = 1'b0;  dm_w_en = 4'h0;
        grant_q.delete();  resp_q.delete();  ack_cnt = -1;
`ifdef STARVE_GUARD_EN
        starve = 0;
`endif
        @(posedge clk);  @(posedge clk);  #1;
        rst = 1'b0;
        repeat (4) step();

        // randomized traffic
        force_delay = -1;  use_force_data = 1'b0;
        if_left = 60;  dm_left = 60;  rate = 40;
        drain(3000, "random_mix");

        // both requesters back-to-back
        if_left = 30;  dm_left = 30;  rate = 100;
        drain(3000, "random_continuous");

        repeat (3) step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete (errors=%0d checks=%0d)", errors, checks);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Arbitrates one single-port unified memory between the fetch stage (read-only) and the memory stage (read/write with byte enables). It grants one requester per transaction, drives the memory port from a latched copy of that request, and returns read data with a one-cycle ready pulse. The pipeline controller consumes if_stall/dm_stall to freeze F and M stages while a transaction is pending.

Parameters:
AW, 32, address width
DW, 32, data width
ACK_TIMEOUT, 15, max cycles in a grant state without mem_ack before forced completion (1..255)
MAX_DM_RUN, 4, consecutive DM grants allowed while IF waits (used only with starvation guard)

Ports:
clk  in  1  clock
rst  in  1  reset
if_req  in  1  fetch request, held until if_ready
if_addr  in  AW  fetch address
if_rdata  out  DW  fetch read data, valid with if_ready
if_ready  out  1  one-cycle completion pulse
dm_req  in  1  data request, held until dm_ready
dm_addr  in  AW  data address
dm_wdata  in  DW  store data
dm_w_en  in  4  byte write enables; 0 = load
dm_rdata  out  DW  load data, valid with dm_ready
dm_ready  out  1  one-cycle completion pulse
mem_req  out  1  memory request
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_w_en  out  4  memory byte enables
mem_rdata  in  DW  memory read data, valid with mem_ack
mem_ack  in  1  memory completion
if_stall  out  1  if_req & ~if_ready
dm_stall  out  1  dm_req & ~dm_ready
err  out  1  one-cycle pulse on timeout

Behaviour:
- Reset: rst asynchronous, active-high; clock clk. All registers clear; state IDLE; mem_req, mem_addr, mem_wdata, mem_w_en, if_ready, dm_ready, if_rdata, dm_rdata, err all 0. Reset mid-transaction abandons it; mem_req drops immediately.
- States: IDLE, GRANT_IF, GRANT_DM, RESP.
- IDLE: dm_req -> latch dm_addr/dm_wdata/dm_w_en, go GRANT_DM; else if_req -> latch if_addr, w_en=0, wdata=0, go GRANT_IF. Simultaneous requests: DM wins (older instruction).
- GRANT_x: mem_req=1, mem_* from latch (stable for whole grant). On mem_ack: capture mem_rdata into x_rdata, go RESP with owner=x. Watchdog counter counts grant cycles; reaching ACK_TIMEOUT without ack: x_rdata=0, err=1 for one cycle, go RESP.
- RESP: x_ready=1 for exactly one cycle; mem_req=0; next state IDLE. Requester drops or changes req at the edge ending RESP; new request evaluated in IDLE.
- Latency: zero-wait memory (ack in first grant cycle) gives ready 2 cycles after IDLE samples req; throughput one transaction per 3 cycles.
- Store: dm_rdata captured but don't-care; dm_ready still pulses.
- Inputs changing during grant have no effect; x_rdata holds until next completion for that requester.
- mem_ack outside grant states is ignored.

Optional Feature:
STARVE_GUARD_EN: a counter increments on each DM grant while if_req is high and clears on any IF grant. When counter == MAX_DM_RUN and both request in IDLE, IF wins. Without macro: strict DM priority, no counter.

Decomposition:
- Shared package: state enum (IDLE, GRANT_IF, GRANT_DM, RESP), owner encoding, W_EN_NONE=4'b0000.
- Sub-module arb_watchdog: loadable down-counter with expire output; same design reused for the starvation counter.

Test Plan:
- if_req, addr 0x100, mem_ack in first grant cycle, mem_rdata 0xDEADBEEF -> mem_w_en=0, if_ready pulse 2 cycles after req sampled, if_rdata=0xDEADBEEF.
- if_req and dm_req same cycle, dm_w_en=4'b1111, wdata 0x12345678 -> DM served first (mem_addr=dm_addr), dm_ready, then IF granted in next IDLE.
- mem_ack delayed 5 cycles -> mem_req/mem_addr stable for 5 cycles, if_stall high throughout, one ready pulse.
- No mem_ack -> err pulse after ACK_TIMEOUT=15 grant cycles, ready pulses with rdata 0, return to IDLE.
- Assert rst in GRANT_DM -> mem_req=0 same cycle, no ready pulse, state IDLE after release.
- With STARVE_GUARD_EN, MAX_DM_RUN=4, both requests continuous -> grant pattern DM×4, IF, repeat.
